// File: rtl/xt_pkg.sv
// Shared types and default widths for the x_t buffer loader.
package xt_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned TILE_SIZE = 4;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned WORD_W    = TILE_SIZE * DATA_W;
    localparam int unsigned LANE_W    = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/xt_lane_packer.sv
// Collects elements into TILE_SIZE lanes; flags a finished word and clears the
// lanes so unfilled lanes of a flushed partial word read as zero.
module xt_lane_packer
    import xt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              flush,
    input  logic [DATA_W-1:0] data,
    output logic [LANE_W-1:0] lane_cnt,
    output logic              word_done_c,
    output logic [WORD_W-1:0] word_c
);

    logic [TILE_SIZE-1:0][DATA_W-1:0] lanes;
    logic [TILE_SIZE-1:0][DATA_W-1:0] merged;
    logic                             last_lane_c;

    assign last_lane_c = (lane_cnt == LANE_W'(TILE_SIZE - 1));
    assign word_done_c = push & (flush | last_lane_c);

    // Word as it will look once the incoming element lands in its lane
    always_comb begin
        merged           = lanes;
        merged[lane_cnt] = data;
        word_c           = WORD_W'(merged);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes    <= '0;
            lane_cnt <= '0;
        end else if (clear || word_done_c) begin
            lanes    <= '0;
            lane_cnt <= '0;
        end else if (push) begin
            lanes[lane_cnt] <= data;
            lane_cnt        <= lane_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xt_stream_loader.sv
// Streams x_t elements into the x_t buffer, one frame per start command.
// Optional running checksum enabled by defining XT_LOADER_CHKSUM_EN.
module xt_stream_loader
    import xt_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_short,
    output logic [DATA_W-1:0] chksum
);

    state_e              state;
    logic [ADDR_W-1:0]   word_cnt;
    logic [LANE_W-1:0]   lane_cnt;
    logic                word_done_c;
    word_t               word_c;
    logic                hs_c;
    logic                clear_c;
    logic                frame_end_c;
    logic                early_c;

    assign s_ready     = (state == ST_LOAD);
    assign hs_c        = s_ready & s_valid;
    assign clear_c     = (state == ST_IDLE) & start;
    assign frame_end_c = hs_c & (word_cnt == ADDR_W'(FRAME_WORDS - 1))
                       & (lane_cnt == LANE_W'(TILE_SIZE - 1));
    assign early_c     = hs_c & s_last & ~frame_end_c;

    xt_lane_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear_c),
        .push        (hs_c),
        .flush       (s_last),
        .data        (s_data),
        .lane_cnt    (lane_cnt),
        .word_done_c (word_done_c),
        .word_c      (word_c)
    );

    // Frame FSM with registered write port and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_short <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        word_cnt  <= '0;
                        err_short <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (word_done_c) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= word_cnt;
                        wr_data  <= word_c;
                        word_cnt <= word_cnt + 1'b1;
                    end
                    if (frame_end_c || early_c) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                    if (early_c) begin
                        err_short <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef XT_LOADER_CHKSUM_EN
    // Wrapping sum of accepted elements, cleared on start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum <= '0;
        end else if (clear_c) begin
            chksum <= '0;
        end else if (hs_c) begin
            chksum <= chksum + s_data;
        end
    end
`else
    assign chksum = '0;
`endif

endmodule

// File: tb/tb_xt_stream_loader.sv
// Self-checking bench for xt_stream_loader: vector table, corner sequences,
// and randomized frames against a queue-based frame model.
module tb_xt_stream_loader;

`ifdef XT_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int FRAME_ELEMS = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [63:0] wr_data;
    logic        busy;
    logic        done;
    logic        err_short;
    logic [15:0] chksum;

    int tests = 0;
    int fails = 0;

    logic [15:0] elems [FRAME_ELEMS];
    logic [5:0]  wq_addr [$];
    logic [63:0] wq_data [$];
    int          done_cnt = 0;

    typedef struct {
        string       name;
        int          pattern;   // 0: i, 1: i+1, 2: -1
        int          last_idx;  // -1: no s_last
        int          gap;       // percent idle cycles
        int          exp_writes;
        logic [63:0] exp_first;
        logic [63:0] exp_last;
        logic        exp_err;
        logic [15:0] exp_chk;
    } vec_t;

    xt_stream_loader #(.FRAME_WORDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err_short (err_short),
        .chksum    (chksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
    endtask

    // Drives elements 0..n_send-1; returns #1 after the last accepted edge.
    task automatic feed(input int n_send, input int lidx, input int gap,
                        input bit do_start, input bit hold);
        int guard;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
        end
        guard = 0;
        while (!s_ready && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_after_start", s_ready, 1);
        for (int i = 0; i < n_send; i++) begin
            bit acc;
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard <= 200) begin
                if (gap > 0 && $urandom_range(99) < gap) begin
                    s_valid = 1'b0;
                end else begin
                    s_valid = 1'b1;
                    s_data  = elems[i];
                    s_last  = (i == lidx);
                end
                acc = s_valid && s_ready;
                @(posedge clk); #1;
                s_valid = 1'b0;
                s_last  = 1'b0;
                guard++;
            end
            if (!acc) begin
                check("handshake_timeout", 0, 1);
                return;
            end
        end
    endtask

    // Frame model: n accepted elements packed 4 per word, zero-filled tail.
    task automatic verify_frame(input string tag, input int n);
        int          nw;
        logic [63:0] w;
        logic [15:0] s;
        nw = (n + 3) / 4;
        check({tag, "_nwrites"}, 64'(wq_data.size()), 64'(nw));
        for (int k = 0; k < nw && k < wq_data.size(); k++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (4 * k + j < n) w[16*j +: 16] = elems[4*k+j];
            check({tag, "_addr"}, 64'(wq_addr[k]), 64'(k));
            check({tag, "_data"}, wq_data[k], w);
        end
        s = '0;
        for (int i = 0; i < n; i++) s = s + elems[i];
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_err_short"}, 64'(err_short), 64'(n < FRAME_ELEMS));
        check({tag, "_chksum"}, 64'(chksum), CHK_EN ? 64'(s) : 64'd0);
    endtask

    task automatic fill(input int pattern);
        for (int i = 0; i < FRAME_ELEMS; i++)
            elems[i] = (pattern == 0) ? 16'(i) : (pattern == 1) ? 16'(i + 1) : 16'hFFFF;
    endtask

    initial begin
        vec_t vecs [5];
        int   n;
        int   lidx;

        vecs[0] = '{"full_seq", 0, -1, 0, 64, 64'h0003_0002_0001_0000,
                    64'h00FF_00FE_00FD_00FC, 1'b0, 16'h7F80};
        vecs[1] = '{"full_gaps", 0, 255, 50, 64, 64'h0003_0002_0001_0000,
                    64'h00FF_00FE_00FD_00FC, 1'b0, 16'h7F80};
        vecs[2] = '{"early_last", 1, 5, 0, 2, 64'h0004_0003_0002_0001,
                    64'h0000_0000_0006_0005, 1'b1, 16'h0015};
        vecs[3] = '{"negative", 2, 3, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16'hFFFC};
        vecs[4] = '{"last_on_word", 0, 7, 30, 2, 64'h0003_0002_0001_0000,
                    64'h0007_0006_0005_0004, 1'b1, 16'h001C};

        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_ctrl", {s_ready, wr_en, wr_addr, busy, done, err_short, chksum}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[v]) begin
            fill(vecs[v].pattern);
            lidx = vecs[v].last_idx;
            n    = (lidx < 0) ? FRAME_ELEMS : lidx + 1;
            clear_mon();
            feed(n, lidx, vecs[v].gap, 1'b1, 1'b0);
            check({vecs[v].name, "_done_t1"}, done, 1);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check({vecs[v].name, "_busy_idle"}, busy, 0);
            check({vecs[v].name, "_count"}, 64'(wq_data.size()), 64'(vecs[v].exp_writes));
            if (wq_data.size() > 0) begin
                check({vecs[v].name, "_first"}, wq_data[0], vecs[v].exp_first);
                check({vecs[v].name, "_last"}, wq_data[wq_data.size()-1], vecs[v].exp_last);
            end
            check({vecs[v].name, "_err"}, err_short, vecs[v].exp_err);
            check({vecs[v].name, "_chk"}, chksum, CHK_EN ? 64'(vecs[v].exp_chk) : 64'd0);
            verify_frame(vecs[v].name, n);
        end

        // Reset in the middle of a frame drops the partial second word
        fill(0);
        clear_mon();
        feed(6, -1, 0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wr_data", wr_data, 64'd0);
        check("midrst_ctrl", {s_ready, wr_en, wr_addr, busy, done, err_short, chksum}, 64'd0);
        check("midrst_nwrites", 64'(wq_data.size()), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_quiet", 64'(wq_data.size()), 64'd1);
        clear_mon();
        feed(FRAME_ELEMS, -1, 0, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        verify_frame("after_rst", FRAME_ELEMS);

        // start held high: one frame per IDLE visit, relaunch at T+3
        clear_mon();
        feed(FRAME_ELEMS, -1, 0, 1'b1, 1'b1);
        check("hold_t1_done", done, 1);
        check("hold_t1_ready", s_ready, 0);
        @(posedge clk); #1;
        check("hold_t2", {done, s_ready, busy}, 64'd0);
        @(posedge clk); #1;
        check("hold_t3_ready", s_ready, 1);
        check("hold_t3_busy", busy, 1);
        verify_frame("hold_f1", FRAME_ELEMS);
        clear_mon();
        fill(1);
        feed(FRAME_ELEMS, -1, 0, 1'b0, 1'b1);
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("hold_no_third", s_ready, 0);
        verify_frame("hold_f2", FRAME_ELEMS);

        // Randomized frames against the model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < FRAME_ELEMS; i++) elems[i] = 16'($urandom_range(65535));
            lidx = ($urandom_range(1) == 1) ? int'($urandom_range(255)) : -1;
            n    = (lidx < 0) ? FRAME_ELEMS : lidx + 1;
            clear_mon();
            feed(n, lidx, int'($urandom_range(60)), 1'b1, 1'b0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            verify_frame("rand", n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
